// File: rtl/c4_board_if.sv
// rtl/c4_board_if.sv - move request / result / cell read bundle between game controller and board engine
interface c4_board_if;
  logic       move_req;
  logic [2:0] move_col;
  logic       move_player;
  logic       busy;
  logic       done;
  logic       move_valid;
  logic       win;
  logic       draw;
  logic [2:0] rd_col;
  logic [2:0] rd_row;
  logic [1:0] rd_cell;

  modport master (
    output move_req, move_col, move_player, rd_col, rd_row,
    input  busy, done, move_valid, win, draw, rd_cell
  );

  modport slave (
    input  move_req, move_col, move_player, rd_col, rd_row,
    output busy, done, move_valid, win, draw, rd_cell
  );
endinterface

// File: rtl/c4_board_engine.sv
// rtl/c4_board_engine.sv - Connect-4 board store, drop validation and line scan for win/draw
module c4_board_engine #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int WIN_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  c4_board_if.slave  bus
);

  localparam logic [2:0]        COLS3     = 3'(COLS);
  localparam logic [2:0]        ROWS3     = 3'(ROWS);
  localparam logic signed [3:0] COLS_S    = 4'(COLS);
  localparam logic signed [3:0] ROWS_S    = 4'(ROWS);
  localparam logic [2:0]        WIN3      = 3'(WIN_LEN);
  localparam logic [1:0]        LAST_STEP = 2'(WIN_LEN - 2);
  localparam logic [5:0]        CELLS     = 6'(COLS * ROWS);

  typedef enum logic [2:0] {
    IDLE, CHECK, WRITE, SCAN_POS, SCAN_NEG, NEXT_DIR, REPORT
  } state_t;

  state_t state, state_next;

  logic [1:0]        board  [COLS][ROWS];
  logic [2:0]        height [COLS];
  logic [5:0]        moves;
  logic [2:0]        col_q;
  logic              player_q;
  logic signed [3:0] org_c, org_r, pc, pr;
  logic [1:0]        dir;
  logic [2:0]        count;
  logic [1:0]        steps;
  logic              done_q, valid_q, win_q, draw_q;
  logic [1:0]        rd_q;

  logic              move_ok, probe_on, probe_match, side_end, win_hit, scanning;
  logic [1:0]        probe_cell;

  // Direction order: horizontal, vertical, diagonal /, diagonal \.
  function automatic logic signed [3:0] step_c(input logic [1:0] d);
    logic signed [3:0] s;
    s = (d == 2'd1) ? 4'sd0 : 4'sd1;
    return s;
  endfunction

  function automatic logic signed [3:0] step_r(input logic [1:0] d);
    logic signed [3:0] s;
    case (d)
      2'd0:    s = 4'sd0;
      2'd1:    s = 4'sd1;
      2'd2:    s = 4'sd1;
      default: s = -4'sd1;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst || clear) state <= IDLE;
    else               state <= state_next;
  end

  always_comb begin
    state_next  = state;
    move_ok     = (col_q < COLS3) && (height[col_q] < ROWS3);
    probe_on    = (pc >= 4'sd0) && (pc < COLS_S) && (pr >= 4'sd0) && (pr < ROWS_S);
    // Gate the read so off-board coordinates never index the array.
    probe_cell  = probe_on ? board[pc[2:0]][pr[2:0]] : 2'b00;
    probe_match = probe_on && (probe_cell == {player_q, ~player_q});
    win_hit     = probe_match && ((count + 3'd1) >= WIN3);
    side_end    = !probe_match || (steps == LAST_STEP);
    scanning    = (state == SCAN_POS) || (state == SCAN_NEG);
    case (state)
      IDLE:     if (bus.move_req) state_next = CHECK;
      CHECK:    state_next = move_ok ? WRITE : REPORT;
      WRITE:    state_next = SCAN_POS;
      SCAN_POS: if (win_hit) state_next = REPORT;
                else if (side_end) state_next = SCAN_NEG;
      SCAN_NEG: if (win_hit) state_next = REPORT;
                else if (side_end) state_next = NEXT_DIR;
      NEXT_DIR: state_next = (dir == 2'd3) ? REPORT : SCAN_POS;
      REPORT:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      for (int c = 0; c < COLS; c++) begin
        height[c] <= 3'd0;
        for (int r = 0; r < ROWS; r++) board[c][r] <= 2'b00;
      end
      moves    <= 6'd0;
      col_q    <= 3'd0;
      player_q <= 1'b0;
      org_c    <= 4'sd0;
      org_r    <= 4'sd0;
      pc       <= 4'sd0;
      pr       <= 4'sd0;
      dir      <= 2'd0;
      count    <= 3'd0;
      steps    <= 2'd0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      win_q    <= 1'b0;
      draw_q   <= 1'b0;
      rd_q     <= 2'b00;
    end else begin
      rd_q   <= ((bus.rd_col < COLS3) && (bus.rd_row < ROWS3)) ? board[bus.rd_col][bus.rd_row] : 2'b00;
      done_q <= 1'b0;
      // Results are loaded on entry to REPORT so they are valid alongside done.
      if (state != REPORT && state_next == REPORT) begin
        done_q  <= 1'b1;
        valid_q <= (state != CHECK);
        win_q   <= scanning && win_hit;
        draw_q  <= (state == NEXT_DIR) && (moves == CELLS);
      end
      case (state)
        IDLE: if (bus.move_req) begin
          col_q    <= bus.move_col;
          player_q <= bus.move_player;
        end
        WRITE: begin
          board[col_q][height[col_q]] <= {player_q, ~player_q};
          height[col_q] <= height[col_q] + 3'd1;
          moves         <= moves + 6'd1;
          org_c         <= {1'b0, col_q};
          org_r         <= {1'b0, height[col_q]};
          pc            <= {1'b0, col_q} + 4'sd1;
          pr            <= {1'b0, height[col_q]};
          dir           <= 2'd0;
          count         <= 3'd1;
          steps         <= 2'd0;
        end
        SCAN_POS: begin
          if (probe_match) count <= count + 3'd1;
          if (side_end) begin
            pc    <= org_c - step_c(dir);
            pr    <= org_r - step_r(dir);
            steps <= 2'd0;
          end else begin
            pc    <= pc + step_c(dir);
            pr    <= pr + step_r(dir);
            steps <= steps + 2'd1;
          end
        end
        SCAN_NEG: begin
          if (probe_match) count <= count + 3'd1;
          pc    <= pc - step_c(dir);
          pr    <= pr - step_r(dir);
          steps <= steps + 2'd1;
        end
        NEXT_DIR: begin
          dir   <= dir + 2'd1;
          count <= 3'd1;
          steps <= 2'd0;
          pc    <= org_c + step_c(dir + 2'd1);
          pr    <= org_r + step_r(dir + 2'd1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;
  assign bus.move_valid = valid_q;
  assign bus.win        = win_q;
  assign bus.draw       = draw_q;
  assign bus.rd_cell    = rd_q;

endmodule

// File: tb/tb_c4_board_engine.sv
// tb/tb_c4_board_engine.sv - directed self-checking bench for c4_board_engine
module tb_c4_board_engine;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  int   tests = 0;
  int   fails = 0;

  c4_board_if bus();

  c4_board_engine dut (.clk(clk), .rst(rst), .clear(clear), .bus(bus));

  always #5 clk = ~clk;

  task automatic drop(input logic [2:0] c, input logic p, output int lat);
    @(negedge clk);
    bus.move_req = 1'b1; bus.move_col = c; bus.move_player = p;
    @(posedge clk);
    @(negedge clk);
    bus.move_req = 1'b0;
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic rd(input logic [2:0] c, input logic [2:0] r, output logic [1:0] v);
    @(negedge clk);
    bus.rd_col = c; bus.rd_row = r;
    @(negedge clk);
    v = bus.rd_cell;
  endtask

  task automatic do_clear;
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic count_nonempty(output int n);
    logic [1:0] v;
    n = 0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        rd(3'(c), 3'(r), v);
        if (v !== 2'b00) n++;
      end
  endtask

  task automatic test_reset;
    logic [4:0] got;
    bus.rd_col = 3'd0; bus.rd_row = 3'd0;
    repeat (3) @(negedge clk);
    got = {bus.busy, bus.done, bus.move_valid, bus.win, bus.draw};
    tests++;
    if (got !== 5'b0 || bus.rd_cell !== 2'b00) begin
      fails++; $display("FAIL reset_outputs got=%b/%b want=00000/00", got, bus.rd_cell);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_single;
    int lat; logic [1:0] v;
    drop(3'd3, 1'b0, lat);
    tests++;
    if (lat != 15 || bus.move_valid !== 1'b1 || bus.win !== 1'b0 || bus.draw !== 1'b0) begin
      fails++; $display("FAIL single_move lat=%0d v/w/d=%b%b%b want lat=15 100", lat, bus.move_valid, bus.win, bus.draw);
    end
    @(negedge clk);
    tests++;
    if (bus.done !== 1'b0 || bus.move_valid !== 1'b1) begin
      fails++; $display("FAIL done_pulse done=%b valid=%b want 0 1", bus.done, bus.move_valid);
    end
    rd(3'd3, 3'd0, v);
    tests++;
    if (v !== 2'b01) begin fails++; $display("FAIL read_3_0 got=%b want=01", v); end
    rd(3'd3, 3'd1, v);
    tests++;
    if (v !== 2'b00) begin fails++; $display("FAIL read_3_1 got=%b want=00", v); end
  endtask

  task automatic test_column_full;
    int lat; int bad; logic [1:0] v;
    do_clear;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      drop(3'd0, 1'(i % 2), lat);
      if (bus.move_valid !== 1'b1 || bus.win !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL col_fill_valid bad=%0d want=0", bad); end
    drop(3'd0, 1'b0, lat);
    tests++;
    if (lat != 2 || bus.move_valid !== 1'b0 || bus.win !== 1'b0 || bus.draw !== 1'b0) begin
      fails++; $display("FAIL seventh_drop lat=%0d v/w/d=%b%b%b want lat=2 000", lat, bus.move_valid, bus.win, bus.draw);
    end
    rd(3'd0, 3'd5, v);
    tests++;
    if (v !== 2'b10) begin fails++; $display("FAIL read_0_5 got=%b want=10", v); end
    drop(3'd0, 1'b1, lat);
    tests++;
    if (lat != 2 || bus.move_valid !== 1'b0) begin
      fails++; $display("FAIL eighth_drop lat=%0d valid=%b want 2 0", lat, bus.move_valid);
    end
  endtask

  task automatic test_bad_col;
    int lat; int n;
    do_clear;
    drop(3'd7, 1'b0, lat);
    tests++;
    if (lat != 2 || bus.move_valid !== 1'b0 || bus.win !== 1'b0) begin
      fails++; $display("FAIL col7_drop lat=%0d valid=%b win=%b want 2 0 0", lat, bus.move_valid, bus.win);
    end
    count_nonempty(n);
    tests++;
    if (n != 0) begin fails++; $display("FAIL col7_board nonempty=%0d want=0", n); end
  endtask

  task automatic test_horizontal;
    int lat; int bad;
    do_clear;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      drop(3'(i), 1'b0, lat);
      if (bus.win !== 1'b0 || bus.move_valid !== 1'b1) bad++;
      drop(3'd6, 1'b1, lat);
      if (bus.win !== 1'b0 || bus.move_valid !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL horiz_setup bad=%0d want=0", bad); end
    drop(3'd3, 1'b0, lat);
    tests++;
    if (lat != 7 || bus.win !== 1'b1 || bus.move_valid !== 1'b1 || bus.draw !== 1'b0) begin
      fails++; $display("FAIL horiz_win lat=%0d v/w/d=%b%b%b want lat=7 110", lat, bus.move_valid, bus.win, bus.draw);
    end
  endtask

  task automatic test_diagonal;
    int lat; logic prev_win;
    logic [2:0] cols [10];
    logic       pl   [10];
    cols = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
    pl   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_clear;
    prev_win = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drop(cols[i], pl[i], lat);
      prev_win = prev_win | bus.win;
    end
    tests++;
    if (prev_win !== 1'b0) begin fails++; $display("FAIL diag_setup win=%b want=0", prev_win); end
    drop(cols[9], pl[9], lat);
    tests++;
    if (lat != 13 || bus.win !== 1'b1 || bus.move_valid !== 1'b1) begin
      fails++; $display("FAIL diag_win lat=%0d valid=%b win=%b want 13 1 1", lat, bus.move_valid, bus.win);
    end
  endtask

  task automatic test_vertical;
    int lat;
    do_clear;
    for (int i = 0; i < 3; i++) drop(3'd5, 1'b1, lat);
    tests++;
    if (bus.win !== 1'b0) begin fails++; $display("FAIL vert_three win=%b want=0", bus.win); end
    drop(3'd5, 1'b1, lat);
    tests++;
    if (lat != 10 || bus.win !== 1'b1 || bus.move_valid !== 1'b1) begin
      fails++; $display("FAIL vert_win lat=%0d valid=%b win=%b want 10 1 1", lat, bus.move_valid, bus.win);
    end
  endtask

  // Player at (c,r) = (r&1)^((c>>1)&1): no four-in-line exists anywhere on the full board.
  task automatic test_draw;
    int lat; int early; int lat_bad; logic w41;
    do_clear;
    early = 0; lat_bad = 0; w41 = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        drop(3'(c), 1'((r & 1) ^ ((c >> 1) & 1)), lat);
        if (lat < 11 || lat > 31) lat_bad++;
        if (r * 7 + c < 41) begin
          if (bus.draw !== 1'b0 || bus.win !== 1'b0 || bus.move_valid !== 1'b1) early++;
        end
        if (r * 7 + c == 40) w41 = bus.draw;
      end
    tests++;
    if (early != 0) begin fails++; $display("FAIL draw_early bad=%0d want=0", early); end
    tests++;
    if (w41 !== 1'b0) begin fails++; $display("FAIL draw_move41 got=%b want=0", w41); end
    tests++;
    if (bus.draw !== 1'b1 || bus.win !== 1'b0 || bus.move_valid !== 1'b1) begin
      fails++; $display("FAIL draw_move42 v/w/d=%b%b%b want 101", bus.move_valid, bus.win, bus.draw);
    end
    tests++;
    if (lat_bad != 0) begin fails++; $display("FAIL draw_latency out_of_range=%0d want=0", lat_bad); end
    drop(3'd4, 1'b0, lat);
    tests++;
    if (lat != 2 || bus.move_valid !== 1'b0 || bus.draw !== 1'b0) begin
      fails++; $display("FAIL full_board_drop lat=%0d valid=%b draw=%b want 2 0 0", lat, bus.move_valid, bus.draw);
    end
  endtask

  task automatic test_abort(input bit use_rst);
    int lat; int n; int seen;
    do_clear;
    drop(3'd0, 1'b0, lat);
    drop(3'd1, 1'b1, lat);
    @(negedge clk);
    bus.move_req = 1'b1; bus.move_col = 3'd3; bus.move_player = 1'b0;
    @(posedge clk);
    @(negedge clk); bus.move_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
    if (use_rst) rst = 1'b0; else clear = 1'b1;
    @(negedge clk);
    rst = 1'b1; clear = 1'b0;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.move_valid !== 1'b0) begin
      fails++; $display("FAIL abort_outputs rst=%0b busy=%b done=%b valid=%b want 0 0 0", use_rst, bus.busy, bus.done, bus.move_valid);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL abort_no_done rst=%0b pulses=%0d want=0", use_rst, seen); end
    count_nonempty(n);
    tests++;
    if (n != 0) begin fails++; $display("FAIL abort_board rst=%0b nonempty=%0d want=0", use_rst, n); end
  endtask

  initial begin
    bus.move_req = 1'b0; bus.move_col = 3'd0; bus.move_player = 1'b0;
    bus.rd_col = 3'd0; bus.rd_row = 3'd0;
    test_reset;
    test_single;
    test_column_full;
    test_bad_col;
    test_horizontal;
    test_diagonal;
    test_vertical;
    test_draw;
    test_abort(1'b0);
    test_abort(1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
